// File: rtl/slice_cascade_cmp.sv
// -----------------------------------------------------------------------------
// slice_cascade_cmp
//
// Sequential cascade stage that sits after a 4-bit combinational magnitude
// comparator. It takes one nibble result (greater / less / equal) per input
// handshake, most-significant nibble first. After NSLICE nibbles it presents
// the relation of the full 4*NSLICE-bit operands on a valid/ready output.
// It also keeps saturating counts of completed gt / lt / eq results.
//
// state   | meaning
// --------+-------------------------------------------------------------------
// COLLECT | accepting nibble results (in_ready=1, res_valid=0)
// HOLD    | full-width result presented, waiting for res_ready (in_ready=0)
//
// Parameters
//   NSLICE    nibbles per operand (2..16)
//   CNT_W     width of each statistics counter
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  nibble-result handshake
//   in_g/l/e        nibble result: A>B, A<B, A==B (expected one-hot)
//   res_valid/ready full-width result handshake
//   res_gt/lt/eq    full-width relation (exactly one high when res_err=0)
//   res_err         at least one nibble result in the word was not one-hot
//   gt/lt/eq_count  saturating counts of completed results
// -----------------------------------------------------------------------------
module slice_cascade_cmp #(
    parameter int NSLICE = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_g,
    input  logic             in_l,
    input  logic             in_e,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_gt,
    output logic             res_lt,
    output logic             res_eq,
    output logic             res_err,
    output logic [CNT_W-1:0] gt_count,
    output logic [CNT_W-1:0] lt_count,
    output logic [CNT_W-1:0] eq_count
);

    localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             decided_q, decided_d;
    logic             dir_gt_q, dir_gt_d;
    logic             err_q, err_d;
    logic             res_gt_q, res_gt_d;
    logic             res_lt_q, res_lt_d;
    logic             res_eq_q, res_eq_d;
    logic             res_err_q, res_err_d;
    logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
    logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;
    logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;

    logic accept;
    logic res_hs;
    logic slice_onehot;
    logic decided_nxt;
    logic dir_gt_nxt;
    logic err_nxt;

    // Handshake strobes come from the state register only, so res_ready
    // never reaches in_ready combinationally.
    assign in_ready  = (state_q == ST_COLLECT);
    assign res_valid = (state_q == ST_HOLD);
    assign accept    = in_ready && in_valid;
    assign res_hs    = res_valid && res_ready;

    always_comb begin
        slice_onehot = 1'b0;
        case ({in_g, in_l, in_e})
            3'b100, 3'b010, 3'b001: slice_onehot = 1'b1;
            default:                slice_onehot = 1'b0;
        endcase
    end

    // The first non-equal nibble wins; later nibbles cannot change direction.
    assign decided_nxt = decided_q | in_g | in_l;
    assign dir_gt_nxt  = decided_q ? dir_gt_q : in_g;
    assign err_nxt     = err_q | ~slice_onehot;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        dir_gt_d  = dir_gt_q;
        err_d     = err_q;
        res_gt_d  = res_gt_q;
        res_lt_d  = res_lt_q;
        res_eq_d  = res_eq_q;
        res_err_d = res_err_q;
        gt_cnt_d  = gt_cnt_q;
        lt_cnt_d  = lt_cnt_q;
        eq_cnt_d  = eq_cnt_q;

        if (accept) begin
            decided_d = decided_nxt;
            dir_gt_d  = dir_gt_nxt;
            err_d     = err_nxt;
            if (idx_q == IDX_LAST) begin
                // Last nibble: fold it in and register the word's result.
                state_d   = ST_HOLD;
                res_err_d = err_nxt;
                res_gt_d  = ~err_nxt &  decided_nxt &  dir_gt_nxt;
                res_lt_d  = ~err_nxt &  decided_nxt & ~dir_gt_nxt;
                res_eq_d  = ~err_nxt & ~decided_nxt;
            end else begin
                idx_d = idx_q + IDX_ONE;
            end
        end

        if (res_hs) begin
            state_d   = ST_COLLECT;
            idx_d     = '0;
            decided_d = 1'b0;
            dir_gt_d  = 1'b0;
            err_d     = 1'b0;
            res_gt_d  = 1'b0;
            res_lt_d  = 1'b0;
            res_eq_d  = 1'b0;
            res_err_d = 1'b0;
            // Error results have all relation flags low, so they count nowhere.
            if (res_gt_q && (gt_cnt_q != CNT_MAX)) gt_cnt_d = gt_cnt_q + CNT_ONE;
            if (res_lt_q && (lt_cnt_q != CNT_MAX)) lt_cnt_d = lt_cnt_q + CNT_ONE;
            if (res_eq_q && (eq_cnt_q != CNT_MAX)) eq_cnt_d = eq_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_COLLECT;
            idx_q     <= '0;
            decided_q <= 1'b0;
            dir_gt_q  <= 1'b0;
            err_q     <= 1'b0;
            res_gt_q  <= 1'b0;
            res_lt_q  <= 1'b0;
            res_eq_q  <= 1'b0;
            res_err_q <= 1'b0;
            gt_cnt_q  <= '0;
            lt_cnt_q  <= '0;
            eq_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            dir_gt_q  <= dir_gt_d;
            err_q     <= err_d;
            res_gt_q  <= res_gt_d;
            res_lt_q  <= res_lt_d;
            res_eq_q  <= res_eq_d;
            res_err_q <= res_err_d;
            gt_cnt_q  <= gt_cnt_d;
            lt_cnt_q  <= lt_cnt_d;
            eq_cnt_q  <= eq_cnt_d;
        end
    end

    assign res_gt   = res_gt_q;
    assign res_lt   = res_lt_q;
    assign res_eq   = res_eq_q;
    assign res_err  = res_err_q;
    assign gt_count = gt_cnt_q;
    assign lt_count = lt_cnt_q;
    assign eq_count = eq_cnt_q;

endmodule
